// File: rtl/sap1_controller_sequencer_if.sv
// Control bus between the SAP-1 controller-sequencer and the datapath:
// opcode in from the IR, T-state and the full control word out.
interface sap1_controller_sequencer_if #(
    parameter int OPC_W = 4
);
    logic [OPC_W-1:0] OPCODE;
    logic [5:0]       T;
    logic             Cp;
    logic             Ep;
    logic             Lm_bar;
    logic             CE_bar;
    logic             Li_bar;
    logic             Ei_bar;
    logic             La_bar;
    logic             Ea;
    logic             Su;
    logic             Eu;
    logic             Lb_bar;
    logic             Lo_bar;
    logic             HLT_bar;

    modport master (
        input  OPCODE,
        output T, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar,
               La_bar, Ea, Su, Eu, Lb_bar, Lo_bar, HLT_bar
    );

    modport slave (
        output OPCODE,
        input  T, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar,
               La_bar, Ea, Su, Eu, Lb_bar, Lo_bar, HLT_bar
    );
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 ring counter plus control decoder; everything registered on the falling edge.
// Optional macro SAP1_VARIABLE_CYCLE_EN skips the no-op T-states of short instructions.
module sap1_controller_sequencer #(
    parameter int NUM_TSTATES = 6,
    parameter int OPC_W       = 4
) (
    input  logic                          CLK,
    input  logic                          CLR,
    sap1_controller_sequencer_if.master   bus,
    output logic [2:0]                    dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_bar;
        logic ce_bar;
        logic li_bar;
        logic ei_bar;
        logic la_bar;
        logic ea;
        logic su;
        logic eu;
        logic lb_bar;
        logic lo_bar;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF = '{cp: 1'b0, ep: 1'b0, lm_bar: 1'b1, ce_bar: 1'b1,
                                   li_bar: 1'b1, ei_bar: 1'b1, la_bar: 1'b1, ea: 1'b0,
                                   su: 1'b0, eu: 1'b0, lb_bar: 1'b1, lo_bar: 1'b1};

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'b0000);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'b0001);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'b0010);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'b1110);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'b1111);

    state_t                 state_q, state_d;
    ctrl_t                  ctrl_q, ctrl_d;
    logic [NUM_TSTATES-1:0] t_q, t_d;
    logic                   hlt_bar_q, hlt_bar_d;
    logic                   is_mem_op;
    logic                   is_arith_op;

    assign is_arith_op = (bus.OPCODE == OP_ADD) || (bus.OPCODE == OP_SUB);
    assign is_mem_op   = (bus.OPCODE == OP_LDA) || is_arith_op;

    always_comb begin
        state_d   = state_q;
        ctrl_d    = CTRL_OFF;
        t_d       = '0;
        hlt_bar_d = 1'b1;

        case (state_q)
            S_IDLE:  state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = (bus.OPCODE == OP_HLT) ? S_HALT : S_T4;
`ifdef SAP1_VARIABLE_CYCLE_EN
            S_T4:    state_d = is_mem_op ? S_T5 : S_T1;
            S_T5:    state_d = is_arith_op ? S_T6 : S_T1;
`else
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
`endif
            S_T6:    state_d = S_T1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Control word is decoded from the state being entered, so it lands with T.
        case (state_d)
            S_T1: begin
                t_d[0]        = 1'b1;
                ctrl_d.ep     = 1'b1;
                ctrl_d.lm_bar = 1'b0;
            end
            S_T2: begin
                t_d[1]    = 1'b1;
                ctrl_d.cp = 1'b1;
            end
            S_T3: begin
                t_d[2]        = 1'b1;
                ctrl_d.ce_bar = 1'b0;
                ctrl_d.li_bar = 1'b0;
            end
            S_T4: begin
                t_d[3] = 1'b1;
                if (is_mem_op) begin
                    ctrl_d.ei_bar = 1'b0;
                    ctrl_d.lm_bar = 1'b0;
                end else if (bus.OPCODE == OP_OUT) begin
                    ctrl_d.ea     = 1'b1;
                    ctrl_d.lo_bar = 1'b0;
                end
            end
            S_T5: begin
                t_d[4] = 1'b1;
                if (bus.OPCODE == OP_LDA) begin
                    ctrl_d.ce_bar = 1'b0;
                    ctrl_d.la_bar = 1'b0;
                end else if (is_arith_op) begin
                    ctrl_d.ce_bar = 1'b0;
                    ctrl_d.lb_bar = 1'b0;
                end
            end
            S_T6: begin
                t_d[5] = 1'b1;
                if (is_arith_op) begin
                    ctrl_d.su     = (bus.OPCODE == OP_SUB);
                    ctrl_d.eu     = 1'b1;
                    ctrl_d.la_bar = 1'b0;
                end
            end
            S_HALT: begin
                t_d[3]    = 1'b1;
                hlt_bar_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            ctrl_q    <= CTRL_OFF;
            t_q       <= '0;
            hlt_bar_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            t_q       <= t_d;
            hlt_bar_q <= hlt_bar_d;
        end
    end

    assign bus.T       = t_q;
    assign bus.Cp      = ctrl_q.cp;
    assign bus.Ep      = ctrl_q.ep;
    assign bus.Lm_bar  = ctrl_q.lm_bar;
    assign bus.CE_bar  = ctrl_q.ce_bar;
    assign bus.Li_bar  = ctrl_q.li_bar;
    assign bus.Ei_bar  = ctrl_q.ei_bar;
    assign bus.La_bar  = ctrl_q.la_bar;
    assign bus.Ea      = ctrl_q.ea;
    assign bus.Su      = ctrl_q.su;
    assign bus.Eu      = ctrl_q.eu;
    assign bus.Lb_bar  = ctrl_q.lb_bar;
    assign bus.Lo_bar  = ctrl_q.lo_bar;
    assign bus.HLT_bar = hlt_bar_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
SAP-1 controller-sequencer. A six-state ring counter generates T1..T6, and a decoder combines the current T-state with the instruction-register opcode to produce the 12-bit control word plus the halt signal. It drives every load and enable line in the SAP-1 datapath: PC, MAR, RAM, IR, A, ALU, B and OUT. It sits beside the instruction register and replaces the discrete 74LS107 ring counter and the control ROM/matrix.

Parameters:
NUM_TSTATES, 6, ring length; fixed at 6 for SAP-1 and not to be overridden.
OPC_W, 4, opcode width taken from IR[7:4].

Ports:
CLK  input  1  system clock; all state updates on the falling edge.
CLR  input  1  asynchronous active-high reset.
OPCODE  input  OPC_W  upper nibble of the instruction register.
T  output  6  one-hot T-state (bit0=T1 .. bit5=T6); all zero = idle.
Cp  output  1  PC increment.
Ep  output  1  PC enable onto W bus.
Lm_bar  output  1  MAR load, active low.
CE_bar  output  1  RAM enable onto bus, active low.
Li_bar  output  1  IR load, active low.
Ei_bar  output  1  IR low-nibble enable onto bus, active low.
La_bar  output  1  A load, active low.
Ea  output  1  A enable onto bus.
Su  output  1  ALU subtract select.
Eu  output  1  ALU enable onto bus.
Lb_bar  output  1  B load, active low.
Lo_bar  output  1  OUT register load, active low.
HLT_bar  output  1  halt flag, active low; gates the system clock externally.

Behaviour:
- CLR high, asynchronous, effective immediately:
  - T=000000 (idle).
  - All control outputs inactive: active-high=0, *_bar=1.
  - HLT_bar=1.
  - Any instruction in progress is abandoned.
- All state and outputs are registered and change only on the CLK falling edge. Outputs are therefore stable across the following rising edge, where the datapath registers capture.
- First falling edge after CLR deasserts: idle -> T1.
- Ring sequence: T1->T2->T3->T4->T5->T6->T1, one state per falling edge.
- Control word is registered alongside T and is a function of the next T-state and OPCODE. Unlisted signals are inactive.
  - T1 (all opcodes): Ep=1, Lm_bar=0.
  - T2: Cp=1.
  - T3: CE_bar=0, Li_bar=0.
  - T4, LDA/ADD/SUB (0000/0001/0010): Ei_bar=0, Lm_bar=0.
  - T4, OUT (1110): Ea=1, Lo_bar=0.
  - T5, LDA: CE_bar=0, La_bar=0.
  - T5, ADD/SUB: CE_bar=0, Lb_bar=0.
  - T6, ADD: Eu=1, La_bar=0.
  - T6, SUB: Su=1, Eu=1, La_bar=0.
  - All other T5/T6 combinations: no-op, all inactive.
- OPCODE requirements:
  - Sampled at each falling edge that enters T4, T5 or T6.
  - Must be stable from the end of T3, since the IR loads on the T3 rising edge.
  - Changes during T1..T3 are ignored.
- HLT (1111):
  - On entering T4, HLT_bar goes 0, T holds at 001000, and all control outputs are inactive.
  - The ring stays frozen on every further edge; only CLR releases it.
- Undefined opcodes (0011..1101): T4..T6 are no-ops and the ring still cycles normally.
- Simultaneous events:
  - CLR dominates any edge.
  - CLR deasserting coincident with a falling edge: the sequencer stays idle for that edge and enters T1 on the next falling edge.
- Invariant: T is always one-hot or all zero. Implementations must never produce two hot bits.

Optional Feature:
Macro: SAP1_VARIABLE_CYCLE_EN
- Defined: no-op T-states are skipped.
  - After T4, OUT and undefined opcodes return directly to T1.
  - After T5, LDA returns directly to T1.
  - ADD/SUB still use all six states.
  - HLT behaviour is unchanged.
- Undefined: fixed six-state machine cycle for every instruction.

Test Plan:
- Reset and startup: CLR=1 for 3 cycles, then 0 -> T=000000 with all outputs inactive until the first falling edge, then T=000001, Ep=1, Lm_bar=0. Next edge: T=000010, Cp=1.
- LDA (OPCODE=0000):
  - T4: Ei_bar=0, Lm_bar=0.
  - T5: CE_bar=0, La_bar=0.
  - T6: all inactive.
  - Following edge: T=000001.
  - With SAP1_VARIABLE_CYCLE_EN: T5 is followed directly by T1.
- SUB (OPCODE=0010): T5 gives CE_bar=0, Lb_bar=0. T6 gives Su=1, Eu=1, La_bar=0. The ADD variant (0001) gives Su=0 at T6.
- OUT then HLT:
  - OUT (1110) at T4: Ea=1, Lo_bar=0.
  - HLT (1111) on the next instruction: at T4, HLT_bar=0 and T=001000, held for 10 further edges.
  - CLR pulse -> HLT_bar=1 and T=000000.
- Mid-instruction reset: assert CLR midway through the ADD T5 low phase -> T=000000 and Lb_bar=1 within the same timestep, with no clock edge required.
- Undefined opcode (0101): T4..T6 all inactive and T returns to 000001 after T6. With SAP1_VARIABLE_CYCLE_EN, T returns to 000001 after T4.
